// File: rtl/pong_pkg.sv
// Shared playfield constants and game-flow state codes for the pong blocks.
package pong_pkg;

    localparam int MAX_X     = 640;
    localparam int MAX_Y     = 480;
    localparam int BALL_SIZE = 10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_MISS  = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

endpackage

// File: rtl/bcd2_sat_counter.sv
// Two-digit BCD incrementer that saturates at 99; clr and rst both zero it.
module bcd2_sat_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       clr,
    output logic [7:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != 8'h99)) begin
            if (count[3:0] == 4'd9) begin
                count <= {count[7:4] + 4'd1, 4'd0};
            end else begin
                count <= {count[7:4], count[3:0] + 4'd1};
            end
        end
    end

endmodule

// File: rtl/pong_game_ctrl.sv
// Game-flow controller: serve/play/miss sequencing, BCD score and lives.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int MAX_X        = pong_pkg::MAX_X,
    parameter int BALL_SIZE    = pong_pkg::BALL_SIZE,
    parameter int LIVES        = 3,
    parameter int SERVE_FRAMES = 60,
    parameter int MISS_FRAMES  = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       refr_tick,
    input  logic       start_btn,
    input  logic [9:0] ball_x,
    input  logic [9:0] ball_y,
    input  logic       paddle_hit,
    output logic       ball_hold,
    output logic [7:0] score_bcd,
    output logic [2:0] lives,
    output logic       miss_flash,
    output logic       game_over,
    output logic [2:0] state
);

    localparam logic [9:0] MISS_LIMIT = 10'(MAX_X - BALL_SIZE);
    localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
    localparam logic [7:0] MISS_LAST  = 8'(MISS_FRAMES - 1);
    localparam logic [2:0] LIVES_INIT = 3'(LIVES);

    state_t     state_q, state_d;
    logic [7:0] frame_q, frame_d;
    logic [2:0] lives_q, lives_d;
    logic       start_q, hit_q;
    logic       start_rise, hit_rise, miss;
    logic       score_inc, score_clr;
    logic       unused_ball_y;

    assign unused_ball_y = ^ball_y;
    assign start_rise    = start_btn & ~start_q;
    assign hit_rise      = paddle_hit & ~hit_q;
    assign miss          = ball_x > MISS_LIMIT;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            frame_q <= '0;
            lives_q <= LIVES_INIT;
            start_q <= 1'b0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            lives_q <= lives_d;
            start_q <= start_btn;
            hit_q   <= paddle_hit;
        end
    end

    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        lives_d   = lives_q;
        score_inc = 1'b0;
        score_clr = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start_rise) begin
                    score_clr = 1'b1;
                    lives_d   = LIVES_INIT;
                    frame_d   = '0;
                    state_d   = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (refr_tick) begin
                    if (frame_q == SERVE_LAST) begin
                        frame_d = '0;
                        state_d = ST_PLAY;
                    end else begin
                        frame_d = frame_q + 8'd1;
                    end
                end
            end
            ST_PLAY: begin
                // A miss on the same edge as a paddle edge takes precedence.
                if (miss) begin
                    lives_d = lives_q - 3'd1;
                    frame_d = '0;
                    state_d = ST_MISS;
                end else begin
                    score_inc = hit_rise;
                end
            end
            ST_MISS: begin
                if (refr_tick) begin
                    if (frame_q == MISS_LAST) begin
                        frame_d = '0;
                        state_d = (lives_q == 3'd0) ? ST_OVER : ST_SERVE;
                    end else begin
                        frame_d = frame_q + 8'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    bcd2_sat_counter u_score (
        .clk   (clk),
        .rst   (rst),
        .inc   (score_inc),
        .clr   (score_clr),
        .count (score_bcd)
    );

    assign ball_hold  = (state_q != ST_PLAY);
    assign miss_flash = (state_q == ST_MISS);
    assign game_over  = (state_q == ST_OVER);
    assign lives      = lives_q;
    assign state      = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed and randomized bench for pong_game_ctrl against an integer-level game model.
module tb_pong_game_ctrl;

    logic       clk = 1'b0;
    logic       rst, refr_tick, start_btn, paddle_hit;
    logic [9:0] ball_x, ball_y;
    logic       ball_hold, miss_flash, game_over;
    logic [7:0] score_bcd;
    logic [2:0] lives, state;

    int errors = 0;
    int checks = 0;

    // Model: game phase code, score as a plain integer 0..99, lives, frame count.
    int m_st, m_score, m_lives, m_fc;
    bit m_pstart, m_phit;

    always #5 clk = ~clk;

    pong_game_ctrl #(
        .MAX_X(640), .BALL_SIZE(10), .LIVES(3), .SERVE_FRAMES(60), .MISS_FRAMES(30)
    ) dut (
        .clk(clk), .rst(rst), .refr_tick(refr_tick), .start_btn(start_btn),
        .ball_x(ball_x), .ball_y(ball_y), .paddle_hit(paddle_hit),
        .ball_hold(ball_hold), .score_bcd(score_bcd), .lives(lives),
        .miss_flash(miss_flash), .game_over(game_over), .state(state)
    );

    function automatic logic [7:0] to_bcd(int s);
        return 8'(((s / 10) << 4) | (s % 10));
    endfunction

    task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit sr, hr;
        sr = start_btn && !m_pstart;
        hr = paddle_hit && !m_phit;
        m_pstart = start_btn;
        m_phit   = paddle_hit;
        if (rst) begin
            m_st = 0; m_score = 0; m_lives = 3; m_fc = 0;
            m_pstart = 0; m_phit = 0;
        end else begin
            case (m_st)
                0, 4: if (sr) begin m_score = 0; m_lives = 3; m_fc = 0; m_st = 1; end
                1: if (refr_tick) begin
                       if (m_fc == 59) begin m_fc = 0; m_st = 2; end else m_fc++;
                   end
                2: if (ball_x > 630) begin m_lives--; m_fc = 0; m_st = 3; end
                   else if (hr && m_score < 99) m_score++;
                3: if (refr_tick) begin
                       if (m_fc == 29) begin m_fc = 0; m_st = (m_lives == 0) ? 4 : 1; end
                       else m_fc++;
                   end
                default: m_st = 0;
            endcase
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        chk("state", 8'(state), 8'(m_st));
        chk("ball_hold", 8'(ball_hold), 8'(m_st != 2));
        chk("score", score_bcd, to_bcd(m_score));
        chk("lives", 8'(lives), 8'(m_lives));
        chk("miss_flash", 8'(miss_flash), 8'(m_st == 3));
        chk("game_over", 8'(game_over), 8'(m_st == 4));
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic hit_pulses(int n);
        for (int i = 0; i < n; i++) begin
            paddle_hit = 1'b1; cycle();
            paddle_hit = 1'b0; cycle();
        end
    endtask

    task automatic start_pulse();
        start_btn = 1'b1; cycle();
        start_btn = 1'b0;
    endtask

    initial begin
        rst = 1'b1; refr_tick = 1'b0; start_btn = 1'b0; paddle_hit = 1'b0;
        ball_x = 10'd320; ball_y = 10'd240;
        m_st = 0; m_score = 0; m_lives = 3; m_fc = 0; m_pstart = 0; m_phit = 0;
        run(2);
        rst = 1'b0;
        chk("reset_state", 8'(state), 8'd0);
        chk("reset_hold", 8'(ball_hold), 8'd1);
        chk("reset_lives", 8'(lives), 8'd3);
        run(2);

        // Serve takes exactly 60 frame ticks
        start_pulse();
        chk("t1_serve", 8'(state), 8'd1);
        refr_tick = 1'b1;
        run(59);
        chk("t1_still_serve", 8'(state), 8'd1);
        run(1);
        refr_tick = 1'b0;
        chk("t1_play", 8'(state), 8'd2);
        chk("t1_hold", 8'(ball_hold), 8'd0);
        chk("t1_score", score_bcd, 8'h00);

        hit_pulses(10);
        chk("t2_score10", score_bcd, 8'h10);
        paddle_hit = 1'b1; run(20); paddle_hit = 1'b0; run(1);
        chk("t2_score11", score_bcd, 8'h11);

        ball_x = 10'd630; run(3);
        chk("t3_edge_play", 8'(state), 8'd2);
        ball_x = 10'd631; start_btn = 1'b1; run(1);
        ball_x = 10'd320;
        chk("t3_miss", 8'(state), 8'd3);
        chk("t3_lives", 8'(lives), 8'd2);
        chk("t3_flash", 8'(miss_flash), 8'd1);
        run(1); start_btn = 1'b0;
        refr_tick = 1'b1; run(29);
        chk("t3_still_miss", 8'(state), 8'd3);
        run(1);
        chk("t3_serve", 8'(state), 8'd1);
        run(60); refr_tick = 1'b0;

        paddle_hit = 1'b1; ball_x = 10'd700; run(1);
        paddle_hit = 1'b0; ball_x = 10'd320;
        chk("t4_miss", 8'(state), 8'd3);
        chk("t4_score", score_bcd, 8'h11);

        refr_tick = 1'b1; run(30 + 60);
        ball_x = 10'd1023; run(1); ball_x = 10'd320;
        chk("t5_lives0", 8'(lives), 8'd0);
        run(30); refr_tick = 1'b0;
        chk("t5_over", 8'(state), 8'd4);
        chk("t5_game_over", 8'(game_over), 8'd1);
        hit_pulses(2);
        chk("t5_frozen", score_bcd, 8'h11);
        start_pulse();
        chk("t5_restart", 8'(state), 8'd1);
        chk("t5_lives3", 8'(lives), 8'd3);
        chk("t5_score0", score_bcd, 8'h00);

        for (int i = 0; i < 800; i++) begin
            start_btn  = ($urandom_range(0, 15) == 0);
            paddle_hit = 1'($urandom_range(0, 1));
            refr_tick  = ($urandom_range(0, 3) != 0);
            ball_x     = ($urandom_range(0, 39) == 0) ? 10'($urandom_range(631, 1023))
                                                      : 10'($urandom_range(0, 630));
            ball_y     = 10'($urandom_range(0, 479));
            cycle();
        end
        start_btn = 1'b0; paddle_hit = 1'b0; refr_tick = 1'b0; ball_x = 10'd320;

        // Saturation and mid-game reset from a clean game
        rst = 1'b1; run(1); rst = 1'b0; run(1);
        start_pulse();
        refr_tick = 1'b1; run(60); refr_tick = 1'b0;
        chk("t6_play", 8'(state), 8'd2);
        hit_pulses(99);
        chk("t6_score99", score_bcd, 8'h99);
        hit_pulses(1);
        chk("t6_sat", score_bcd, 8'h99);
        rst = 1'b1; run(1); rst = 1'b0;
        chk("t6_rst_state", 8'(state), 8'd0);
        chk("t6_rst_score", score_bcd, 8'h00);
        chk("t6_rst_lives", 8'(lives), 8'd3);
        chk("t6_rst_hold", 8'(ball_hold), 8'd1);
        chk("t6_rst_flags", {6'd0, miss_flash, game_over}, 8'd0);
        run(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
- Game-flow controller: consumes the ball position and paddle-contact status, and drives the ball's restart/hold control back to it.
- Counts paddle returns as a 2-digit BCD score and tracks remaining lives.
- Sequences the game through IDLE/SERVE/PLAY/MISS/OVER.
- Sits between the ball and paddle blocks and the score/VGA overlay logic.

Parameters:
- MAX_X, 640, visible width in pixels.
- BALL_SIZE, 10, ball edge length in pixels.
- LIVES, 3, lives at game start (1..7).
- SERVE_FRAMES, 60, refr_ticks the ball is held before release (1..255).
- MISS_FRAMES, 30, refr_ticks spent in MISS (1..255).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- refr_tick  in  1  one-cycle pulse per frame.
- start_btn  in  1  already-synchronized start button level.
- ball_x  in  10  ball left edge, from the ball block.
- ball_y  in  10  ball top edge; unused for decisions, reserved.
- paddle_hit  in  1  level: ball overlaps the paddle.
- ball_hold  out  1  1 = keep the ball at centre. Top level drives ball rstn = ~(rst | ball_hold).
- score_bcd  out  8  [7:4] tens, [3:0] units.
- lives  out  3  remaining lives.
- miss_flash  out  1  high while in MISS.
- game_over  out  1  high while in OVER.
- state  out  3  state code, for debug and overlay.

Behaviour:
Clock and reset:
- One clock; reset is synchronous and active-high (clk, rst).
- All state updates on posedge clk; rst has priority over everything.
- Reset values: state=IDLE, ball_hold=1, score_bcd=8'h00, lives=LIVES, miss_flash=0, game_over=0, frame_cnt=0, start_q=0, hit_q=0.
- rst asserted mid-game returns every output to these reset values on the next edge.

Edge detection:
- start_q and hit_q register the previous input levels every cycle.
- start_rise = start_btn & ~start_q.
- hit_rise = paddle_hit & ~hit_q.

Miss condition (combinational):
- miss = ball_x > MAX_X-BALL_SIZE, compared in 10-bit unsigned (i.e. 631..1023).

States (codes IDLE=0, SERVE=1, PLAY=2, MISS=3, OVER=4):
- IDLE: ball_hold=1. On start_rise: score<=0, lives<=LIVES, frame_cnt<=0, go to SERVE.
- SERVE: ball_hold=1.
  - On each refr_tick, frame_cnt increments.
  - On a refr_tick with frame_cnt==SERVE_FRAMES-1: frame_cnt<=0, go to PLAY.
  - The first PLAY cycle has ball_hold=0.
- PLAY: ball_hold=0.
  - If miss: lives<=lives-1, frame_cnt<=0, go to MISS. This happens on the same edge, independent of refr_tick.
  - Else if hit_rise: score increments in BCD; units wrap 9->0 with a carry into tens.
  - Score saturates at 99; a further hit leaves it at 8'h99.
  - Miss and hit_rise in the same cycle: the miss wins and the score is unchanged.
- MISS: ball_hold=1, miss_flash=1.
  - On a refr_tick with frame_cnt==MISS_FRAMES-1: go to OVER if lives==0, else SERVE; frame_cnt<=0 in both cases.
- OVER: ball_hold=1, game_over=1; score and lives are frozen.
  - On start_rise: score<=0, lives<=LIVES, go to SERVE (same as from IDLE).

Other rules:
- start_rise is ignored in SERVE, PLAY and MISS.
- hit_rise is ignored outside PLAY.
- A paddle_hit held high across several cycles counts once.
- frame_cnt is 8 bits and advances only on refr_tick in SERVE and MISS; it is held elsewhere.
- All outputs are registered or decoded directly from the state register; there is no combinational path from inputs to outputs.

Decomposition:
- Package pong_pkg holds:
  - constants MAX_X=640, MAX_Y=480, BALL_SIZE=10;
  - 3-bit state encodings ST_IDLE..ST_OVER.
- The ball block takes its constants from the same package.
- One sub-module, bcd2_sat_counter: 2-digit saturating BCD incrementer with inc/clr inputs and a synchronous active-high reset.

Test Plan:
1. Reset, then start_btn high for 1 cycle → state SERVE, ball_hold=1. After exactly 60 refr_ticks → state PLAY, ball_hold=0, score=8'h00, lives=3.
2. In PLAY, paddle_hit pulses 10 times (separated) → score=8'h10. Then hold paddle_hit high for 20 cycles → score=8'h11.
3. In PLAY, ball_x=631 → next edge MISS, lives=2, miss_flash=1. After 30 refr_ticks → SERVE. ball_x=630 alone → stays in PLAY.
4. Hit rising edge and ball_x=700 in the same cycle → MISS, score unchanged.
5. Three misses → OVER, game_over=1, lives=0. Start pulse → SERVE, lives=3, score=8'h00.
6. Score preset to 99 via 99 hits, then one more hit → stays 8'h99. rst asserted mid-PLAY → next edge IDLE with all reset values.
